// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared types and constants for the UART SRAM transmit path.
// Holds the word-FSM state enum, bus widths and the default bit period.
package uart_sram_tx_interface_pkg;

    localparam int unsigned ADDR_W                 = 18;
    localparam int unsigned DATA_W                 = 16;
    localparam int unsigned CLOCKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_READ,
        S_TX_WAIT,
        S_TX_LATCH,
        S_TX_HI,
        S_TX_LO,
        S_TX_DONE
    } tx_state_type;

    // Latched transfer parameters; addr advances and count drains as words go out
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] count;
    } tx_req_t;

endpackage

// File: rtl/uart_sram_tx_interface_if.sv
// Control handshake and SRAM read-port bundle for the UART transmit block.
interface uart_sram_tx_interface_if;
    import uart_sram_tx_interface_pkg::*;

    logic              Start;
    logic [ADDR_W-1:0] Start_address;
    logic [ADDR_W-1:0] Word_count;
    logic              Busy;
    logic              Done;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_read_data;
    logic              SRAM_we_n;

    modport master (
        output Start, Start_address, Word_count, SRAM_read_data,
        input  Busy, Done, SRAM_address, SRAM_we_n
    );

    modport slave (
        input  Start, Start_address, Word_count, SRAM_read_data,
        output Busy, Done, SRAM_address, SRAM_we_n
    );

endinterface

// File: rtl/uart_sram_tx_interface_tx_byte.sv
// 8N1 byte serialiser: start bit, LSB-first data, stop bit.
// Ready marks the last stop-bit cycle so a Load there chains frames gap-free.
module uart_tx_byte
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [7:0] Data,
    output logic       TX,
    output logic       Ready
);

    localparam int unsigned TIMER_W  = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int unsigned STOP_IDX = 9;

    logic               r_active;
    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_bit_idx;
    logic [8:0]         r_shift;
    logic               r_tx;

    logic w_bit_end;
    logic w_last;
    logic w_accept;

    assign w_bit_end = (r_timer == TIMER_W'(CLOCKS_PER_BIT - 1));
    assign w_last    = r_active && w_bit_end && (r_bit_idx == 4'(STOP_IDX));
    assign w_accept  = Load && (!r_active || w_last);

    assign TX    = r_tx;
    assign Ready = w_last;

    // Bit index 0 is the start bit, 1..8 data, 9 the stop bit
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_active  <= 1'b0;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '1;
            r_tx      <= 1'b1;
        end else if (w_accept) begin
            r_active  <= 1'b1;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= {1'b1, Data};
            r_tx      <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_timer <= '0;
                if (r_bit_idx == 4'(STOP_IDX)) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                    r_tx      <= r_shift[0];
                    r_shift   <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads a block of 16-bit SRAM words and sends them as 8N1 bytes, high byte first.
// The next word is prefetched while the low byte is on the line.
module uart_sram_tx_interface
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    uart_sram_tx_interface_if.slave   bus,
    output logic                      UART_TX_O
);

    tx_state_type      r_state;
    tx_req_t           r_req;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_prefetch;
    logic [1:0]        r_lo_cycle;
    logic              r_busy;
    logic              r_done;

    tx_state_type      w_state_next;
    tx_req_t           w_req_next;
    logic [DATA_W-1:0] w_word_next;
    logic [DATA_W-1:0] w_prefetch_next;
    logic [1:0]        w_lo_cycle_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_load;
    logic [7:0]        w_load_data;
    logic              w_ready;

    assign bus.Busy         = r_busy;
    assign bus.Done         = r_done;
    assign bus.SRAM_address = r_req.addr;
    assign bus.SRAM_we_n    = 1'b1;

    uart_tx_byte #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_tx_byte (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Load   (w_load),
        .Data   (w_load_data),
        .TX     (UART_TX_O),
        .Ready  (w_ready)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= S_TX_IDLE;
            r_req      <= '0;
            r_word     <= '0;
            r_prefetch <= '0;
            r_lo_cycle <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_req      <= w_req_next;
            r_word     <= w_word_next;
            r_prefetch <= w_prefetch_next;
            r_lo_cycle <= w_lo_cycle_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_req_next      = r_req;
        w_word_next     = r_word;
        w_prefetch_next = r_prefetch;
        w_lo_cycle_next = r_lo_cycle;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_load          = 1'b0;
        w_load_data     = r_word[7:0];

        unique case (r_state)
            S_TX_IDLE: begin
                if (bus.Start) begin
                    w_req_next = '{addr: bus.Start_address, count: bus.Word_count};
                    if (bus.Word_count == '0) begin
                        w_state_next = S_TX_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_TX_READ;
                        w_busy_next  = 1'b1;
                    end
                end
            end
            S_TX_READ:  w_state_next = S_TX_WAIT;
            S_TX_WAIT:  w_state_next = S_TX_LATCH;
            S_TX_LATCH: begin
                w_word_next      = bus.SRAM_read_data;
                w_load           = 1'b1;
                w_load_data      = bus.SRAM_read_data[15:8];
                w_req_next.count = r_req.count - ADDR_W'(1);
                w_state_next     = S_TX_HI;
            end
            S_TX_HI: begin
                if (w_ready) begin
                    w_load          = 1'b1;
                    w_load_data     = r_word[7:0];
                    w_lo_cycle_next = '0;
                    // Present the next word's address on the first low-byte cycle
                    if (r_req.count != '0) begin
                        w_req_next.addr = r_req.addr + ADDR_W'(1);
                    end
                    w_state_next = S_TX_LO;
                end
            end
            S_TX_LO: begin
                if (r_lo_cycle != 2'd3) begin
                    w_lo_cycle_next = r_lo_cycle + 2'd1;
                end
                if ((r_lo_cycle == 2'd2) && (r_req.count != '0)) begin
                    w_prefetch_next = bus.SRAM_read_data;
                end
                if (w_ready) begin
                    if (r_req.count != '0) begin
                        w_load           = 1'b1;
                        w_load_data      = r_prefetch[15:8];
                        w_word_next      = r_prefetch;
                        w_req_next.count = r_req.count - ADDR_W'(1);
                        w_state_next     = S_TX_HI;
                    end else begin
                        w_state_next = S_TX_DONE;
                        w_done_next  = 1'b1;
                        w_busy_next  = 1'b0;
                    end
                end
            end
            S_TX_DONE: w_state_next = S_TX_IDLE;
            default:   w_state_next = S_TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Self-checking bench: directed table, reset/Start-ignore sequences and random
// transfers, decoded off the serial line and compared with a word-list model.
module tb_uart_sram_tx_interface;
    import uart_sram_tx_interface_pkg::*;

    localparam int CPB  = 4;
    localparam int MAXC = 1024;

    logic Clock = 1'b0;
    logic Resetn;
    logic UART_TX_O;

    uart_sram_tx_interface_if bus();

    uart_sram_tx_interface #(
        .CLOCKS_PER_BIT (CPB)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .bus       (bus),
        .UART_TX_O (UART_TX_O)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // SRAM with two-cycle read latency
    logic [15:0] mem [logic [17:0]];
    logic [15:0] sram_d1;

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'hC3C3;
    endfunction

    always @(posedge Clock) begin
        sram_d1            <= mem_rd(bus.SRAM_address);
        bus.SRAM_read_data <= sram_d1;
    end

    // Per-cycle log; index k is the value seen at cycle k after Start is sampled
    logic        line_log [MAXC];
    logic        busy_log [MAXC];
    logic        done_log [MAXC];
    logic        we_log   [MAXC];
    logic [17:0] addr_log [MAXC];
    int          nlog;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input logic [17:0] addr, input logic [17:0] cnt,
                            input int ncyc, input int inj_k, input int rst_k);
        @(negedge Clock);
        bus.Start         = 1'b1;
        bus.Start_address = addr;
        bus.Word_count    = cnt;
        @(posedge Clock);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge Clock);
            line_log[k] = UART_TX_O;
            busy_log[k] = bus.Busy;
            done_log[k] = bus.Done;
            we_log[k]   = bus.SRAM_we_n;
            addr_log[k] = bus.SRAM_address;
            bus.Start   = (k == inj_k);
            if (k == inj_k) begin
                bus.Start_address = ~addr;
                bus.Word_count    = cnt + 18'd5;
            end
            Resetn = (k != rst_k);
        end
        bus.Start = 1'b0;
        Resetn    = 1'b1;
        nlog      = ncyc;
    endtask

    // Compare the logged transfer against the word list read from mem
    task automatic analyze(input string tag, input logic [17:0] addr, input int n, input int exp_done);
        logic [7:0]  exp_bytes [$];
        logic [17:0] exp_addrs [$];
        logic [7:0]  got [$];
        int          starts [$];
        logic [17:0] addrs [$];
        logic [7:0]  b;
        logic [15:0] w;
        int k, done_cnt, done_at, we_low, busy_hi;

        for (int i = 0; i < n; i++) begin
            w = mem_rd(addr + 18'(i));
            exp_bytes.push_back(w[15:8]);
            exp_bytes.push_back(w[7:0]);
            exp_addrs.push_back(addr + 18'(i));
        end

        k = 1;
        while (k + 9 * CPB + CPB / 2 <= nlog) begin
            if (line_log[k] == 1'b0) begin
                starts.push_back(k);
                for (int j = 0; j < 8; j++) b[j] = line_log[k + CPB * (j + 1) + CPB / 2];
                got.push_back(b);
                check($sformatf("%s stop%0d", tag, got.size() - 1),
                      64'(line_log[k + 9 * CPB + CPB / 2]), 64'd1);
                k += 10 * CPB;
            end else begin
                k++;
            end
        end

        check({tag, " nbytes"}, 64'(got.size()), 64'(2 * n));
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 64'(got[i]), 64'(exp_bytes[i]));
        for (int i = 0; i < starts.size(); i++)
            check($sformatf("%s start_cycle%0d", tag, i), 64'(starts[i]), 64'(4 + 10 * CPB * i));

        done_cnt = 0; done_at = -1; we_low = 0; busy_hi = 0;
        for (int i = 1; i <= nlog; i++) begin
            if (done_log[i]) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (!we_log[i]) we_low++;
            if (busy_log[i]) busy_hi++;
        end
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " done_cycle"}, 64'(done_at), 64'(exp_done));
        check({tag, " we_n_low_cycles"}, 64'(we_low), 64'd0);

        if (n == 0) begin
            check({tag, " busy_cycles"}, 64'(busy_hi), 64'd0);
        end else begin
            check({tag, " busy_cycles"}, 64'(busy_hi), 64'(exp_done - 1));
            check({tag, " busy_at_done"}, 64'(busy_log[exp_done]), 64'd0);
            check({tag, " addr_cycle1"}, 64'(addr_log[1]), 64'(addr));
            addrs.push_back(addr_log[1]);
            for (int i = 2; i < exp_done; i++)
                if (addr_log[i] != addrs[addrs.size() - 1]) addrs.push_back(addr_log[i]);
            check({tag, " addr_count"}, 64'(addrs.size()), 64'(n));
            for (int i = 0; i < addrs.size() && i < n; i++)
                check($sformatf("%s addr%0d", tag, i), 64'(addrs[i]), 64'(exp_addrs[i]));
        end
    endtask

    typedef struct {
        string       name;
        logic [17:0] addr;
        logic [17:0] cnt;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          inj_k;
        int          exp_done;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] ra;
        int          rn;
        int          low_after, busy_after, done_any;

        vecs[0] = '{"one_word",      18'h00010, 18'd1, 16'hA55A, 16'h0000, 16'h0000, 0,   84};
        vecs[1] = '{"three_words",   18'h00100, 18'd3, 16'h0102, 16'h0304, 16'h0506, 0,   244};
        vecs[2] = '{"zero_count",    18'h00055, 18'd0, 16'h0000, 16'h0000, 16'h0000, 0,   1};
        vecs[3] = '{"addr_wrap",     18'h3FFFF, 18'd2, 16'hBEEF, 16'h1234, 16'h0000, 0,   164};
        vecs[4] = '{"start_ignored", 18'h00100, 18'd3, 16'h0102, 16'h0304, 16'h0506, 100, 244};

        Resetn            = 1'b0;
        bus.Start         = 1'b0;
        bus.Start_address = '0;
        bus.Word_count    = '0;
        repeat (3) @(negedge Clock);
        check("reset tx",    64'(UART_TX_O),        64'd1);
        check("reset busy",  64'(bus.Busy),         64'd0);
        check("reset done",  64'(bus.Done),         64'd0);
        check("reset addr",  64'(bus.SRAM_address), 64'd0);
        check("reset we_n",  64'(bus.SRAM_we_n),    64'd1);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].cnt > 0) mem[vecs[v].addr]          = vecs[v].w0;
            if (vecs[v].cnt > 1) mem[vecs[v].addr + 18'd1]  = vecs[v].w1;
            if (vecs[v].cnt > 2) mem[vecs[v].addr + 18'd2]  = vecs[v].w2;
            run_xfer(vecs[v].addr, vecs[v].cnt, vecs[v].exp_done + 6, vecs[v].inj_k, 0);
            analyze(vecs[v].name, vecs[v].addr, int'(vecs[v].cnt), vecs[v].exp_done);
            repeat (3) @(negedge Clock);
        end

        // Reset during data bit 4 of the first byte (cycles 24..27)
        mem[18'h00200] = 16'hFFFF;
        mem[18'h00201] = 16'h8001;
        run_xfer(18'h00200, 18'd2, 120, 0, 25);
        check("rst line_next", 64'(line_log[26]), 64'd1);
        check("rst busy_next", 64'(busy_log[26]), 64'd0);
        low_after = 0; busy_after = 0; done_any = 0;
        for (int i = 1; i <= nlog; i++) begin
            if (done_log[i]) done_any++;
            if (i >= 26 && !line_log[i]) low_after++;
            if (i >= 26 && busy_log[i]) busy_after++;
        end
        check("rst done_pulses", 64'(done_any), 64'd0);
        check("rst line_low_after", 64'(low_after), 64'd0);
        check("rst busy_after", 64'(busy_after), 64'd0);
        repeat (2) @(negedge Clock);
        run_xfer(18'h00200, 18'd2, 4 + 40 * CPB + 6, 0, 0);
        analyze("after_reset", 18'h00200, 2, 4 + 40 * CPB);
        repeat (3) @(negedge Clock);

        for (int r = 0; r < 10; r++) begin
            rn = $urandom_range(1, 5);
            if ($urandom_range(0, 2) == 0) ra = 18'h3FFFF - 18'($urandom_range(0, 3));
            else                           ra = 18'($urandom);
            for (int i = 0; i < rn; i++) mem[ra + 18'(i)] = 16'($urandom);
            run_xfer(ra, 18'(rn), 4 + 20 * rn * CPB + 6, 0, 0);
            analyze($sformatf("rand%0d", r), ra, rn, 4 + 20 * rn * CPB);
            repeat ($urandom_range(1, 4)) @(negedge Clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
